// File: rtl/ahb_pkg.sv
// Shared AHB types, response codes, slave state encoding and small
// address helpers for the SRAM slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Data-phase state of the slave.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_e;

    // Little-endian byte lanes touched by a transfer of the given size.
    function automatic logic [3:0] ahb_byte_en(input logic [1:0] lane, input logic [2:0] size);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lane;
            HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    // Address a SEQ beat must carry given the previous beat address.
    function automatic logic [31:0] ahb_seq_addr(input logic [31:0] prev, input logic [2:0] size,
                                                 input logic [2:0] burst);
        logic [31:0] inc;
        logic [31:0] span;
        logic [31:0] nxt;
        inc = 32'd1 << size;
        nxt = prev + inc;
        case (burst)
            HBURST_WRAP4:  span = inc << 2;
            HBURST_WRAP8:  span = inc << 3;
            HBURST_WRAP16: span = inc << 4;
            default:       span = 32'd0;
        endcase
        if (span != 32'd0) begin
            return (prev & ~(span - 32'd1)) | (nxt & (span - 32'd1));
        end else begin
            return nxt;
        end
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Byte-enabled word array: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module ahb_sram_mem #(
    parameter int WORDS = 1024,
    parameter int IW    = 10
) (
    input  logic          HCLK,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [WORDS];

    // Commit only the enabled byte lanes of the addressed word.
    always_ff @(posedge HCLK) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave with programmable wait states and a two-cycle ERROR
// response for out-of-range, oversized or misaligned transfers.
// Optional macro AHB_SRAM_BURST_CHECK_EN adds SEQ-beat address checking
// (INCR/WRAP continuity and 1 KB boundary crossing).
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MEM_BYTES   = 4096,
    parameter int          WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int          WORDS   = MEM_BYTES / 4;
    localparam int          IW      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);
    localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

    slave_state_e  state_r, state_n;
    logic [3:0]    cnt_r, cnt_n;
    logic          hreadyout_r, hreadyout_n;
    logic [1:0]    hresp_r, hresp_n;
    logic [IW-1:0] idx_r;
    logic [1:0]    lane_r;
    logic [2:0]    size_r;
    logic          write_r;

    logic          accept_s, capture_s, err_s;
    logic          range_err_s, size_err_s, align_err_s, burst_err_s;
    logic [31:0]   offset_s, rdata_s;
    logic          we_s;
    logic [3:0]    be_s;
    logic          unused_s;

    assign accept_s    = HSEL & HREADY & HTRANS[1];
    assign offset_s    = HADDR - BASE_ADDR;
    assign range_err_s = ({1'b0, HADDR} < {1'b0, BASE_ADDR}) | ({1'b0, HADDR} >= LIMIT);
    assign size_err_s  = (HSIZE > 3'd2);

    // Alignment check for half-word and word transfers.
    always_comb begin
        align_err_s = 1'b0;
        case (HSIZE)
            HSIZE_HALF: align_err_s = HADDR[0];
            HSIZE_WORD: align_err_s = |HADDR[1:0];
            default:    align_err_s = 1'b0;
        endcase
    end

`ifdef AHB_SRAM_BURST_CHECK_EN
    logic [31:0] prev_addr_r;
    logic [31:0] seq_addr_s;

    assign seq_addr_s  = ahb_seq_addr(prev_addr_r, HSIZE, HBURST);
    assign burst_err_s = (HTRANS == HTRANS_SEQ) &
                         ((HADDR != seq_addr_s) | (HADDR[31:10] != prev_addr_r[31:10]));
    assign unused_s    = ^offset_s;

    // Remember the last accepted address for SEQ continuity checks.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prev_addr_r <= 32'h0000_0000;
        end else if (capture_s) begin
            prev_addr_r <= HADDR;
        end
    end
`else
    // Without the burst check HBURST and the SEQ/NONSEQ distinction are ignored.
    assign burst_err_s = 1'b0;
    assign unused_s    = ^{offset_s, HTRANS[0], HBURST};
`endif

    assign err_s = range_err_s | size_err_s | align_err_s | burst_err_s;

    // Next-state, wait counter and registered-output decode.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        capture_s   = 1'b0;
        hreadyout_n = 1'b1;
        hresp_n     = HRESP_OKAY;
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    capture_s = 1'b1;
                    if (err_s) begin
                        state_n = ST_ERR1;
                    end else if (WS_INIT != 4'd0) begin
                        state_n = ST_WAIT;
                        cnt_n   = WS_INIT;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_n = ST_DATA;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt_r - 4'd1;
                end
            end
            ST_ERR1: begin
                state_n = ST_ERR2;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
        if ((state_n == ST_WAIT) || (state_n == ST_ERR1)) begin
            hreadyout_n = 1'b0;
        end else begin
            hreadyout_n = 1'b1;
        end
        if ((state_n == ST_ERR1) || (state_n == ST_ERR2)) begin
            hresp_n = HRESP_ERROR;
        end else begin
            hresp_n = HRESP_OKAY;
        end
    end

    // State, counter and handshake output registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            hreadyout_r <= hreadyout_n;
            hresp_r     <= hresp_n;
        end
    end

    // Address-phase capture for the following data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_r   <= '0;
            lane_r  <= 2'b00;
            size_r  <= 3'd0;
            write_r <= 1'b0;
        end else if (capture_s) begin
            idx_r   <= offset_s[IW+1:2];
            lane_r  <= HADDR[1:0];
            size_r  <= HSIZE;
            write_r <= HWRITE;
        end
    end

    assign we_s = (state_r == ST_DATA) & write_r;
    assign be_s = ahb_byte_en(lane_r, size_r);

    ahb_sram_mem #(
        .WORDS (WORDS),
        .IW    (IW)
    ) u_mem (
        .HCLK  (HCLK),
        .we    (we_s),
        .be    (be_s),
        .waddr (idx_r),
        .wdata (HWDATA),
        .raddr (idx_r),
        .rdata (rdata_s)
    );

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign HRDATA    = (state_r == ST_DATA) ? rdata_s : 32'h0000_0000;

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Synthesizable AHB slave with a byte-addressable word SRAM and a programmable number of wait states.
- It sits directly downstream of the AHB master driver: it consumes the HTRANS/HADDR/HWDATA address and data phases the master drives, and it produces HREADY, HRESP and HRDATA for the master and monitors.
- It is the reference target for the master-side agent and the scoreboard.

Parameters:
- BASE_ADDR, 32'h0000_0000, first byte address decoded by the slave.
- MEM_BYTES, 4096, memory size in bytes; power of two, at least 4.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (range 0..15).

Ports:
- HCLK  in  1  bus clock; all state updates on its rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
- HBURST  in  3  burst type; used only by the optional feature.
- HWDATA  in  32  write data.
- HREADY  in  1  bus-wide ready, used as address-phase qualifier.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  response: OKAY=00, ERROR=01, RETRY=10, SPLIT=11. Only OKAY and ERROR are ever driven.
- HRDATA  out  32  read data.

Behaviour:
- Reset (asynchronous, HRESETn=0):
  - state=IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, wait counter=0.
  - Memory contents are not cleared.
  - A transfer pending at reset is discarded and its write is not committed.
- Address accept: on a rising edge where HSEL & HREADY & HTRANS[1], capture HADDR, HWRITE and HSIZE.
- IDLE and BUSY transfers, and cycles with HSEL=0, give a zero-wait OKAY and change no memory.
- Error condition on an accepted transfer, any of:
  - HADDR outside [BASE_ADDR, BASE_ADDR+MEM_BYTES);
  - HSIZE > 2;
  - misalignment: HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]≠0.
- State machine (data phase):
  - IDLE: HREADYOUT=1, HRESP=OKAY.
    - Accepted transfer with an error condition -> ERR1.
    - Otherwise WAIT_STATES>0 -> WAIT with counter=WAIT_STATES.
    - Otherwise -> DATA.
  - WAIT: HREADYOUT=0, HRESP=OKAY. Counter decrements each cycle; at 1 -> DATA.
  - DATA: HREADYOUT=1, HRESP=OKAY; the transfer completes on this edge.
    - A new address accepted on the same edge (pipelined) follows the same rules as IDLE.
    - Otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR.
    - A new accepted address follows the IDLE rules; otherwise -> IDLE.
    - No memory access for errored transfers.
- Write:
  - Committed on the DATA completing edge, using HWDATA sampled on that edge.
  - Byte enables come from captured HADDR[1:0] and HSIZE (little-endian lanes).
  - Unselected bytes are unchanged.
- Read:
  - HRDATA equals the full 32-bit word at the captured word address during the DATA cycle; HRDATA=0 in all other states.
  - The read is combinational from the array indexed by the registered address, so a read immediately following a write to the same word returns the new data.
- Word index: (HADDR-BASE_ADDR)[log2(MEM_BYTES)-1:2].

Optional Feature:
- Macro: AHB_SRAM_BURST_CHECK_EN.
- When defined: the slave tracks the previous accepted address and size. An error condition is added for either of:
  - a SEQ transfer whose address ≠ prev+(1<<HSIZE) for INCR types, or ≠ the wrapped address for WRAP4/8/16;
  - a SEQ transfer that crosses a 1 KB boundary.
- Such a transfer takes the ERR1/ERR2 path.
- When undefined: HBURST is ignored and SEQ is treated exactly like NONSEQ.

Decomposition:
- Package ahb_pkg holds:
  - enums htrans_e, hburst_e, hsize_e, hresp_e;
  - slave state enum;
  - constants HRESP_OKAY and HRESP_ERROR.
- Sub-module ahb_sram_mem: byte-enabled word array with one write port and one combinational read port.

Test Plan:
- WAIT_STATES=0: NONSEQ write 32'hDEADBEEF to 0x10, then read 0x10 -> OKAY, no HREADYOUT low, HRDATA=32'hDEADBEEF in the read data cycle.
- Byte write 8'hA5 to 0x13 over word 0x11223344, then word read -> 32'hA5223344.
- WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles, then high with OKAY.
- Read at BASE_ADDR+MEM_BYTES -> cycle 1 {HREADYOUT=0, ERROR}, cycle 2 {1, ERROR}; memory unchanged. Word write at 0x2 -> same two-cycle ERROR.
- Pipelined INCR4 write at 0x0–0xC followed by an INCR4 read -> four back-to-back OKAY data phases returning the written data. Assert HRESETn low mid-burst -> outputs at reset values immediately and the pending write is not committed.
- With AHB_SRAM_BURST_CHECK_EN: INCR4 whose SEQ address jumps 0x4→0xC -> ERROR on that beat. Without the macro -> OKAY.
